rsa_mont_mult: RTL



---
 rtl/rsa_mont_mult.sv | 114 +++++++++++
 1 files changed

// File: rtl/rsa_mont_mult.sv
// Radix-2 bit-serial Montgomery multiplier: result = a*b*2^-WIDTH mod N.
// Each clock runs ITERS_PER_CYCLE iterations, then one clock does the final subtraction.
module rsa_mont_mult #(
   parameter int WIDTH           = 256,
   parameter int ITERS_PER_CYCLE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH:0]   N,
   input  logic [WIDTH:0]   a,
   input  logic [WIDTH:0]   b,
   output logic [WIDTH:0]   result,
   output logic             done,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   localparam int              CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - ITERS_PER_CYCLE);
   localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(ITERS_PER_CYCLE);

   state_t             state_q, state_d;
   logic [WIDTH:0]     n_q, n_d;
   logic [WIDTH:0]     a_q, a_d;
   logic [WIDTH:0]     b_q, b_d;
   logic [WIDTH+1:0]   m_q, m_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH:0]     result_q, result_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic [WIDTH+1:0]   m_iter;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      a_d      = a_q;
      b_d      = b_q;
      m_d      = m_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      done_d   = 1'b0;
      busy_d   = busy_q;

      // a_q is shifted down each clock, so the current multiplier bits sit at [ITERS-1:0].
      m_iter = m_q;
      for (int k = 0; k < ITERS_PER_CYCLE; k++) begin
         if (a_q[k]) m_iter = m_iter + {1'b0, b_q};
         if (m_iter[0]) m_iter = m_iter + {1'b0, n_q};
         m_iter = m_iter >> 1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               n_d     = N;
               a_d     = a;
               b_d     = b;
               m_d     = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            m_d   = m_iter;
            a_d   = a_q >> ITERS_PER_CYCLE;
            cnt_d = cnt_q + CNT_STEP;
            if (cnt_q == CNT_LAST) state_d = S_FIX;
         end
         S_FIX: begin
            // m < 2N, so the corrected value is below N and fits the low WIDTH+1 bits.
            if (m_q >= {1'b0, n_q}) result_d = m_q[WIDTH:0] - n_q;
            else                    result_d = m_q[WIDTH:0];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         n_q      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         m_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         a_q      <= a_d;
         b_q      <= b_d;
         m_q      <= m_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign result = result_q;
   assign done   = done_q;
   assign busy   = busy_q;

endmodule
